// File: rtl/xs3_pkg.sv
// Shared constants and FSM state type for the Excess-3 receive path.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_MIN     = 4'd3;
  localparam logic [3:0] XS3_MAX     = 4'd12;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational Excess-3 to BCD digit decoder; inverse of the BCD to Excess-3 encoder.
module xs3_digit_decode
  import xs3_pkg::*;
(
  input  logic [3:0] in_code,
  output logic [3:0] bcd,
  output logic       illegal
);

  always_comb begin
    illegal = (in_code < XS3_MIN) || (in_code > XS3_MAX);
    bcd     = illegal ? BCD_INVALID : (in_code - XS3_OFFSET);
  end

endmodule

// File: rtl/xs3_to_bcd_packer.sv
// Packs a stream of Excess-3 digits into DIGITS-wide packed-BCD words with a sticky error flag.
module xs3_to_bcd_packer
  import xs3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_code,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  out_count,
  output logic                         out_err
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DIGITS - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         slot_q, slot_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;

  logic [3:0]            dec_bcd;
  logic                  dec_illegal;
  logic                  accept;

  xs3_digit_decode u_decode (
    .in_code (in_code),
    .bcd     (dec_bcd),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (slot_q == CW'(i)) bcd_d[4*i +: 4] = dec_bcd;
          end
          count_d = slot_q + CW'(1);
          err_d   = err_q | dec_illegal;
          if (slot_q == LAST_SLOT || in_last) begin
            state_d = HOLD;
          end else begin
            slot_d = slot_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // Clearing on the handshake edge lets the next word start from empty slots.
        if (out_ready) begin
          state_d = COLLECT;
          slot_d  = '0;
          bcd_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // in_ready is held low during reset even though the state register already reads COLLECT.
  always_comb begin
    in_ready  = rst_n && (state_q == COLLECT);
    out_valid = (state_q == HOLD);
  end

  assign out_bcd   = bcd_q;
  assign out_count = count_q;
  assign out_err   = err_q;

endmodule

// File: doc/xs3_to_bcd_packer.md
# xs3_to_bcd_packer

Stream decoder that accepts Excess-3 coded decimal digits one per handshake, converts each back to plain BCD and packs them into a DIGITS-wide packed-BCD word. It sits downstream of the Excess-3 encoding path, on the receive side of any link carrying Excess-3 digits. It flags any illegal Excess-3 code in the word it delivers.

## Interface
Parameters:
- DIGITS, default 4: digits per output word; legal range 1..16.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_code is presented.
- in_ready  out  1  block accepts a digit this cycle.
- in_code  in  4  Excess-3 digit; legal values 4'h3..4'hC.
- in_last  in  1  qualifies the digit as the last of a short word; sampled only on an accepted beat.
- out_valid  out  1  out_bcd, out_count and out_err are valid.
- out_ready  in  1  downstream accepts the word.
- out_bcd  out  4*DIGITS  packed BCD; digit i occupies [4i+3:4i].
- out_count  out  $clog2(DIGITS+1)  number of digits actually received, 1..DIGITS.
- out_err  out  1  at least one digit in the word was illegal.

## Operation
- A digit is accepted when in_valid && in_ready at a clock edge.
- Decode: legal code c in 3..12 → BCD c-3, 4-bit arithmetic. Codes 0,1,2,13,14,15 are illegal → stored as 4'hF and the sticky error bit is set.
- Packing: the first accepted digit of a word goes to slot 0, the next to slot 1, and so on. A per-word slot counter runs 0..DIGITS-1.
- Unfilled slots of a short word read 4'h0.
- The word closes on whichever comes first: the accepted digit filling slot DIGITS-1, or any accepted digit with in_last=1. in_last on the digit that fills slot DIGITS-1 is redundant and harmless.
- FSM:
  - COLLECT: in_ready=1, out_valid=0. A closing beat → HOLD. Any other accepted beat → stay in COLLECT.
  - HOLD: in_ready=0, out_valid=1, and the outputs are stable. When out_ready=1 → COLLECT, and the slot counter, out_bcd, out_count and out_err clear on that edge.
- in_code and in_last are ignored when the beat is not accepted.
- out_valid stays asserted and outputs stay unchanged until the downstream handshake completes. out_ready while out_valid=0 has no effect.

## Timing
- Reset (rst_n low, asynchronous): state=COLLECT, slot counter=0, out_valid=0, out_bcd=0, out_count=0, out_err=0. in_ready is forced to 0 while rst_n is low and rises to 1 combinationally on release.
- Reset mid-word or during HOLD discards the partial or held word; no output is produced for it.
- Latency: out_valid rises on the edge that accepts the closing digit and is visible in the following cycle.
- Throughput: one digit per cycle within a word, plus one bubble per word. The output-handshake cycle has in_ready=0, so the first digit of the next word is accepted no earlier than the cycle after the out handshake.
- in_ready depends only on the state register, with no combinational path from out_ready. out_valid is registered.
- DIGITS=1: every accepted digit closes a word, and out_count is always 1.

## Structure
- Package xs3_pkg holds:
  - XS3_OFFSET=4'd3, XS3_MIN=4'd3, XS3_MAX=4'd12, BCD_INVALID=4'hF;
  - the FSM state enum {COLLECT, HOLD}.
- Sub-module xs3_digit_decode (combinational): in_code[3:0] → bcd[3:0], illegal. It is the inverse of the BCD→Excess-3 encoder and is reusable by other receive paths.
- Top level holds the FSM, slot counter, packing register, count register and error register.

## Test plan
- DIGITS=4, out_ready=1, codes 4'h4,4'h8,4'hC,4'h3 back-to-back → one word: out_bcd=16'h0951, out_count=4, out_err=0. Then in_ready=0 for exactly one cycle.
- Codes 4'h5,4'hA with in_last on the second → out_bcd=16'h0072, out_count=2, out_err=0.
- Codes 4'h3,4'h0,4'h7,4'hF → out_bcd=16'hF4F0, out_err=1. The following word 4'h6×4 → out_bcd=16'h3333, out_err=0 (error bit cleared).
- Hold out_ready=0 for 10 cycles after the word closes, with in_valid=1 and changing codes → in_ready=0, outputs stable, no digits consumed. Then out_ready=1 → a single transfer.
- Assert rst_n=0 after 2 of 4 digits are accepted → out_valid stays 0. After release, 4 new digits produce a word that contains only the new digits.
- Exhaustive: all 16 codes through xs3_digit_decode → legal codes map to c-3, and exactly 0,1,2,13,14,15 flag illegal.
